// File: rtl/inst_encoder.sv
// RV32I field-level instruction encoder with a small word FIFO and a sequential
// instruction-memory writer (req/ack), used to load generated programs.
module inst_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic [15:0] words_written,
    output logic        err_illegal,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]    LAST_IDX      = 32'(MAX_WORDS - 1);

    localparam logic [2:0] TY_R  = 3'd0;
    localparam logic [2:0] TY_I  = 3'd1;
    localparam logic [2:0] TY_S  = 3'd2;
    localparam logic [2:0] TY_SB = 3'd3;
    localparam logic [2:0] TY_UJ = 3'd4;
    localparam logic [2:0] TY_U  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

    // Pack the request fields into an RV32 word; illegal types yield zero
    // (they never reach the FIFO anyway).
    function automatic logic [31:0] encode_fields(
        input logic [2:0]  ty,
        input logic [6:0]  opc,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (ty)
            TY_R:    w = {f7, rs2, rs1, f3, rd, opc};
            TY_I:    w = {imm[11:0], rs1, f3, rd, opc};
            TY_S:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            TY_SB:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            TY_UJ:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            TY_U:    w = {imm[31:12], rd, opc};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    wr_state_t   state_r;
    wr_state_t   state_nxt_s;
    logic        mem_wr_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] word_idx_r;
    logic [15:0] words_written_r;
    logic        err_illegal_r;

    logic        full_s;
    logic        empty_s;
    logic        accept_s;
    logic        legal_s;
    logic        push_s;
    logic        pop_s;
    logic        load_s;
    logic        done_s;
    logic [31:0] enc_word_s;

    assign full_s     = (count_r == FIFO_FULL_CNT);
    assign empty_s    = (count_r == '0);
    assign in_ready   = !rst && !full_s;
    assign accept_s   = in_valid && in_ready;
    assign legal_s    = (in_type <= TY_U);
    assign push_s     = accept_s && legal_s;
    assign enc_word_s = encode_fields(in_type, in_opcode, in_rd, in_rs1, in_rs2,
                                      in_funct3, in_funct7, in_imm);

    // FIFO storage; data slots need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= enc_word_s;
        end
    end

    // FIFO pointers and occupancy; a pop frees a slot only from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Writer next-state: load a word when idle, retire on ack, chain back-to-back.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    load_s      = 1'b1;
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    done_s = 1'b1;
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        load_s      = 1'b1;
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Writer state and registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_wr_r    <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                mem_wr_r    <= 1'b1;
                mem_wdata_r <= fifo_mem_r[rd_ptr_r];
            end else if (done_s) begin
                mem_wr_r    <= 1'b0;
                mem_wdata_r <= mem_wdata_r;
            end else begin
                mem_wr_r    <= mem_wr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Address sequencing with wrap to the base after MAX_WORDS acknowledged words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r <= BASE_ADDR;
            word_idx_r <= 32'd0;
        end else if (done_s) begin
            if (word_idx_r >= LAST_IDX) begin
                mem_addr_r <= BASE_ADDR;
                word_idx_r <= 32'd0;
            end else begin
                mem_addr_r <= mem_addr_r + 32'd4;
                word_idx_r <= word_idx_r + 32'd1;
            end
        end else begin
            mem_addr_r <= mem_addr_r;
            word_idx_r <= word_idx_r;
        end
    end

    // Saturating write counter and the one-cycle illegal-type flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_written_r <= 16'h0000;
            err_illegal_r   <= 1'b0;
        end else begin
            if (done_s && (words_written_r != 16'hFFFF)) begin
                words_written_r <= words_written_r + 16'd1;
            end else begin
                words_written_r <= words_written_r;
            end
            err_illegal_r <= accept_s && !legal_s;
        end
    end

    assign mem_wr        = mem_wr_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign words_written = words_written_r;
    assign err_illegal   = err_illegal_r;
    assign busy          = !empty_s || (state_r == ST_WRITE);

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Field-level RV32I instruction encoder and instruction-memory loader, the inverse of the core's instruction decoder. It accepts instruction fields (type, opcode, registers, funct, immediate) over a valid/ready handshake and packs them into 32-bit RV32 words. Words are buffered in a small FIFO and written sequentially into instruction memory through a request/acknowledge write port. It is used by the boot/test-program loader and by self-checking benches to build programs that the decoder then consumes.

Parameters:
FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, >=2)
BASE_ADDR, 32'h0000_0000, first instruction-memory byte address written
MAX_WORDS, 256, words before address wraps back to BASE_ADDR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  field request valid
in_ready  out  1  encoder can accept a request this cycle
in_type  in  3  R=0, I=1, S=2, SB=3, UJ=4, U=5; 6 and 7 are illegal
in_opcode  in  7  opcode field
in_rd, in_rs1, in_rs2  in  5 each  register indices
in_funct3  in  3  funct3
in_funct7  in  7  funct7
in_imm  in  32  immediate, byte-offset semantics per type
mem_wr  out  1  instruction-memory write request
mem_addr  out  32  byte address
mem_wdata  out  32  encoded instruction
mem_ack  in  1  memory accepted the write
words_written  out  16  count of acknowledged writes, saturating
err_illegal  out  1  one-cycle pulse on a rejected illegal type
busy  out  1  FIFO non-empty or write outstanding

Behaviour:
- Reset (async, rst=1): in_ready=0 while rst is high; mem_wr=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, err_illegal=0, busy=0. FIFO is emptied. Reset mid-write abandons the write; no ack is expected afterwards.
- Handshake: a transfer occurs when in_valid && in_ready on a rising edge. in_ready = !rst && FIFO not full; it is combinational from FIFO state only.
- Encoding (field packing, MSB to LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - SB: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - UJ: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - Unused fields are ignored.
- Illegal type (6/7): the request is accepted (handshake completes), not enqueued, and err_illegal pulses high the following cycle.
- Latency: the encoded word is registered into the FIFO on the accept edge. The earliest mem_wr assertion is the next cycle. Throughput is 1 word per cycle when mem_ack returns in the same cycle.
- Writer FSM:
  - IDLE: if the FIFO is non-empty, pop the head into mem_wdata, drive mem_addr, set mem_wr=1, go to WRITE.
  - WRITE: hold mem_wr, mem_addr and mem_wdata stable until mem_ack=1.
  - On ack: increment words_written (saturate at 16'hFFFF). Advance mem_addr by 4; after MAX_WORDS words it wraps to BASE_ADDR.
  - After ack: if the FIFO is non-empty, pop the next word and stay in WRITE with mem_wr=1 (back-to-back). Otherwise drop mem_wr and go to IDLE.
- Simultaneous push and pop on a full FIFO: the pop frees the slot in the same cycle only for the next cycle; in_ready does not depend on the pop.
- mem_ack while in IDLE is ignored.
- busy = FIFO non-empty || state==WRITE.

Test Plan:
- addi x1,x0,5 (type 1, opcode 0010011, rd=1, rs1=0, f3=0, imm=5) -> mem_wdata=0x00500093 at mem_addr=BASE_ADDR; mem_wr rises 1 cycle after accept.
- Back-to-back with immediate ack: add x3,x1,x2 (R) -> 0x002081B3; sw x2,8(x1) (S) -> 0x0020A423; beq x1,x2,+8 (SB) -> 0x00208463. Required: addresses 0x0, 0x4, 0x8; words_written=3; mem_wr held continuously.
- jal x1,+16 (UJ) -> 0x010000EF; lui x5,0x12345 (U, imm=0x12345000) -> 0x123452B7.
- Memory stall: hold mem_ack=0 for 10 cycles while pushing 6 requests. Required: in_ready drops after FIFO_DEPTH words are buffered beyond the outstanding write, mem_addr/mem_wdata stay stable, no word is lost or duplicated after ack resumes.
- Push type=7 -> err_illegal pulses for one cycle, words_written unchanged, no mem_wr. Then MAX_WORDS=4 with 5 words -> the fifth address wraps to BASE_ADDR.
- Assert rst during WRITE -> mem_wr=0 and mem_addr=BASE_ADDR immediately (async), FIFO empty, busy=0, counter=0.
